// File: rtl/mnist_frame_loader.sv
// mnist_frame_loader: serial pixel loader and counter sweep sequencer for the
// first fully-connected layer. Collects one frame into a parallel buffer, then
// sweeps `counter` from 0 to COUNTER_END so the neurons process the frame.
// Optional feature macro: FRAME_LAST_CHECK_EN (frame-length checking against
// pix_last; when undefined pix_last is ignored and frame_err is tied low).
module mnist_frame_loader #(
   parameter int unsigned NEURON_WIDTH = 783,
   parameter int unsigned NEURON_BITS  = 8,
   parameter int unsigned COUNTER_END  = 787
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pix_valid,
   output logic                          pix_ready,
   input  logic signed [NEURON_BITS:0]   pix_data,
   input  logic                          pix_last,
   output logic signed [NEURON_BITS:0]   frame_data [0:NEURON_WIDTH],
   output logic [31:0]                   counter,
   output logic                          busy,
   output logic                          done,
   output logic                          frame_err
);

   localparam int unsigned IDX_W = (NEURON_WIDTH > 0) ? $clog2(NEURON_WIDTH + 1) : 1;

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NEURON_WIDTH);
   localparam logic [31:0]      CNT_END  = 32'(COUNTER_END);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] wr_idx_next;
   logic             accept;
   logic             at_last;
   logic             short_frame;
   logic             len_err;

   // Ready is decoded straight from the state so the producer sees it without delay
   assign pix_ready = (state == S_LOAD);
   assign accept    = pix_valid && pix_ready;
   assign at_last   = (wr_idx == IDX_LAST);

`ifdef FRAME_LAST_CHECK_EN
   // A frame is malformed when pix_last disagrees with the final buffer slot
   assign short_frame = pix_last && !at_last;
   assign len_err     = accept && (pix_last != at_last);
`else
   logic unused_pix_last;
   assign unused_pix_last = pix_last;
   assign short_frame     = 1'b0;
   assign len_err         = 1'b0;
`endif

   // Next-state and write-index logic
   always_comb begin
      state_next  = state;
      wr_idx_next = wr_idx;
      case (state)
         S_LOAD: begin
            if (accept) begin
               if (at_last) begin
                  wr_idx_next = '0;
                  state_next  = S_RUN;
               end else if (short_frame) begin
                  wr_idx_next = '0;
               end else begin
                  wr_idx_next = wr_idx + IDX_W'(1);
               end
            end
         end
         S_RUN: begin
            if (counter == CNT_END) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_LOAD;
         end
         default: begin
            state_next = S_LOAD;
         end
      endcase
   end

   // State and write-index registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_LOAD;
         wr_idx <= '0;
      end else begin
         state  <= state_next;
         wr_idx <= wr_idx_next;
      end
   end

   // Registered status outputs and the sweep counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         busy      <= (state_next == S_RUN);
         done      <= (state_next == S_DONE);
         frame_err <= len_err;
         if ((state == S_RUN) && (state_next == S_RUN)) begin
            counter <= counter + 32'd1;
         end else if (state_next == S_LOAD) begin
            counter <= '0;
         end
      end
   end

   // Frame buffer: written only while loading, frozen otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i <= NEURON_WIDTH; i++) begin
            frame_data[i] <= '0;
         end
      end else if (accept) begin
         frame_data[wr_idx] <= pix_data;
      end
   end

endmodule
